// File: rtl/mux_sel_sequencer_if.sv
// Signal bundle between mux_sel_sequencer, its upstream producer, the 8:1 mux and the serial sink.
// slave = the sequencer itself; master = everything around it.
interface mux_sel_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mux_i;
  logic [2:0] mux_s;
  logic       mux_y;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_last;
  logic       busy;

  modport master (
    output in_data, in_valid, mux_y,
    input  in_ready, mux_i, mux_s, ser_data, ser_valid, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid, mux_y,
    output in_ready, mux_i, mux_s, ser_data, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial front end: holds a word on an external 8:1 mux and steps its select every DIV cycles.
// Optional macro MUX_SEL_SEQUENCER_PARITY_EN appends an even-parity bit after the eighth data bit.
module mux_sel_sequencer #(
  parameter int unsigned DIV       = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  mux_sel_sequencer_if.slave  bus
);

  localparam int unsigned            CNT_W     = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0]       DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [2:0]             START_SEL = MSB_FIRST ? 3'd7 : 3'd0;
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
  localparam logic [3:0]             LAST_BIT  = 4'd8;

  function automatic logic even_parity(input logic [7:0] word);
    return ^word;
  endfunction
`else
  localparam logic [3:0]             LAST_BIT  = 4'd7;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [7:0]       mux_i_q;
  logic [2:0]       mux_s_q;
  logic [CNT_W-1:0] div_cnt_q;
  logic [3:0]       bit_cnt_q;
  logic             ser_data_q;
  logic             ser_valid_q;
  logic             ser_last_q;
  logic             busy_q;

  logic             period_end_d;
  logic             last_bit_d;
  logic [2:0]       mux_s_d;

  // Bit-period boundary, final-bit flag and the next select position.
  always_comb begin
    period_end_d = (div_cnt_q == DIV_LAST);
    last_bit_d   = (bit_cnt_q == LAST_BIT);
    if (MSB_FIRST) begin
      mux_s_d = mux_s_q - 3'd1;
    end else begin
      mux_s_d = mux_s_q + 3'd1;
    end
  end

  // Sequencer FSM; mux_y is captured on the same edge that moves the select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mux_i_q     <= 8'h00;
      mux_s_q     <= START_SEL;
      div_cnt_q   <= '0;
      bit_cnt_q   <= 4'd0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ser_valid_q <= 1'b0;
          ser_last_q  <= 1'b0;
          if (bus.in_valid) begin
            mux_i_q   <= bus.in_data;
            mux_s_q   <= START_SEL;
            div_cnt_q <= '0;
            bit_cnt_q <= 4'd0;
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (period_end_d) begin
            div_cnt_q   <= '0;
            bit_cnt_q   <= bit_cnt_q + 4'd1;
            ser_valid_q <= 1'b1;
            ser_last_q  <= last_bit_d;
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
            // The parity slot reads the held word directly and leaves the select parked.
            if (bit_cnt_q == 4'd8) begin
              ser_data_q <= even_parity(mux_i_q);
            end else begin
              ser_data_q <= bus.mux_y;
              mux_s_q    <= mux_s_d;
            end
`else
            ser_data_q <= bus.mux_y;
            mux_s_q    <= mux_s_d;
`endif
            if (last_bit_d) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            div_cnt_q   <= div_cnt_q + CNT_W'(1);
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          ser_valid_q <= 1'b0;
          ser_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.mux_i     = mux_i_q;
  assign bus.mux_s     = mux_s_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: three instances (DIV=1 LSB-first, DIV=4 MSB-first, DIV=3 with bench-driven mux_y).
// Honours MUX_SEL_SEQUENCER_PARITY_EN by expecting a ninth (parity) pulse.
module tb_mux_sel_sequencer;

`ifdef MUX_SEL_SEQUENCER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk;
  logic rst;
  logic glitch_y;
  int   n_checks;
  int   n_fail;

  mux_sel_sequencer_if if1 ();
  mux_sel_sequencer_if if4 ();
  mux_sel_sequencer_if if3 ();

  // Real 8:1 mux for the first two instances; the third sees a bench-controlled mux_y.
  assign if1.mux_y = if1.mux_i[if1.mux_s];
  assign if4.mux_y = if4.mux_i[if4.mux_s];
  assign if3.mux_y = glitch_y;

  mux_sel_sequencer #(.DIV(1), .MSB_FIRST(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  mux_sel_sequencer #(.DIV(4), .MSB_FIRST(1'b1)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  mux_sel_sequencer #(.DIV(3), .MSB_FIRST(1'b0)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (if1.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", if1.in_ready); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (if1.mux_s !== 3'd0) begin n_fail++; $display("FAIL rst_mux_s1: got %0d want 0", if1.mux_s); end
    n_checks++; if (if4.mux_s !== 3'd7) begin n_fail++; $display("FAIL rst_mux_s4: got %0d want 7", if4.mux_s); end
    n_checks++; if (if1.mux_i !== 8'h00) begin n_fail++; $display("FAIL rst_mux_i: got %h want 00", if1.mux_i); end
    n_checks++; if ({if1.ser_data, if1.ser_valid, if1.ser_last, if1.busy} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_outs: got %b want 0000", {if1.ser_data, if1.ser_valid, if1.ser_last, if1.busy});
    end
    rst = 1'b0;
    #1;
    n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", if1.in_ready); end
    @(negedge clk);
    n_checks++; if (if1.ser_valid !== 1'b0 || if1.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: got valid=%b busy=%b want 0 0", if1.ser_valid, if1.busy);
    end
  endtask

  task automatic test_div1_lsb;
    logic [7:0] word;
    logic       exp_bit;
    word = 8'hA5;
    if1.in_data  = word;
    if1.in_valid = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0;
    n_checks++; if (if1.busy !== 1'b1 || if1.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL div1_accept: got busy=%b ready=%b want 1 0", if1.busy, if1.in_ready);
    end
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      exp_bit = (k < 8) ? word[k] : 1'b0;  // parity of A5 is 0
      n_checks++; if (if1.ser_valid !== 1'b1) begin n_fail++; $display("FAIL div1_valid k=%0d: got %b want 1", k, if1.ser_valid); end
      n_checks++; if (if1.ser_data !== exp_bit) begin n_fail++; $display("FAIL div1_data k=%0d: got %b want %b", k, if1.ser_data, exp_bit); end
      n_checks++; if (if1.ser_last !== (k == NB - 1)) begin n_fail++; $display("FAIL div1_last k=%0d: got %b want %b", k, if1.ser_last, (k == NB - 1)); end
    end
    @(negedge clk);
    n_checks++; if (if1.ser_valid !== 1'b0 || if1.in_ready !== 1'b1 || if1.busy !== 1'b0) begin
      n_fail++; $display("FAIL div1_end: got valid=%b ready=%b busy=%b want 0 1 0", if1.ser_valid, if1.in_ready, if1.busy);
    end
    n_checks++; if (if1.mux_s !== 3'd0) begin n_fail++; $display("FAIL div1_wrap: got %0d want 0", if1.mux_s); end
  endtask

  task automatic test_div4_msb;
    logic [7:0] word;
    logic [2:0] exp_s;
    int         step;
    word = 8'h3C;
    n_checks++; if (if4.in_ready !== 1'b1) begin n_fail++; $display("FAIL div4_ready: got %b want 1", if4.in_ready); end
    if4.in_data  = word;
    if4.in_valid = 1'b1;
    @(negedge clk);
    if4.in_valid = 1'b0;
    for (int c = 1; c <= NB * 4; c++) begin
      @(negedge clk);
      step  = (c / 4 > 8) ? 8 : c / 4;
      exp_s = 3'(7 - step);
      n_checks++; if (if4.mux_s !== exp_s) begin n_fail++; $display("FAIL div4_sel c=%0d: got %0d want %0d", c, if4.mux_s, exp_s); end
      n_checks++; if (if4.ser_valid !== (c % 4 == 0)) begin n_fail++; $display("FAIL div4_valid c=%0d: got %b want %b", c, if4.ser_valid, (c % 4 == 0)); end
      n_checks++; if (if4.mux_i !== word) begin n_fail++; $display("FAIL div4_hold c=%0d: got %h want %h", c, if4.mux_i, word); end
      if (c % 4 == 0) begin
        // MSB first: bit index 7-(c/4-1); parity of 3C is 0
        n_checks++; if (if4.ser_data !== ((c / 4 <= 8) ? word[8 - c / 4] : 1'b0)) begin
          n_fail++; $display("FAIL div4_data c=%0d: got %b", c, if4.ser_data);
        end
        n_checks++; if (if4.ser_last !== (c == NB * 4)) begin n_fail++; $display("FAIL div4_last c=%0d: got %b want %b", c, if4.ser_last, (c == NB * 4)); end
      end
    end
    @(negedge clk);
    n_checks++; if (if4.in_ready !== 1'b1 || if4.ser_valid !== 1'b0) begin
      n_fail++; $display("FAIL div4_end: got ready=%b valid=%b want 1 0", if4.in_ready, if4.ser_valid);
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    gap = 0;
    if1.in_data  = 8'hFF;
    if1.in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (if1.mux_i !== 8'hFF) begin n_fail++; $display("FAIL b2b_word0: got %h want ff", if1.mux_i); end
    if1.in_data = 8'h5A;
    for (int j = 1; j <= 40 && gap == 0; j++) begin
      @(negedge clk);
      n_checks++; if (if1.ser_valid !== (j <= NB)) begin n_fail++; $display("FAIL b2b_valid j=%0d: got %b", j, if1.ser_valid); end
      n_checks++; if (if1.ser_data !== (j <= 8)) begin n_fail++; $display("FAIL b2b_data j=%0d: got %b want %b", j, if1.ser_data, (j <= 8)); end
      if (if1.in_ready) begin
        gap = j + 1;
        if1.in_data = 8'h00;
      end else begin
        n_checks++; if (if1.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy j=%0d: got %b want 1", j, if1.busy); end
      end
    end
    n_checks++; if (gap !== NB + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", gap, NB + 1); end
    @(negedge clk);
    if1.in_valid = 1'b0;
    n_checks++; if (if1.mux_i !== 8'h00 || if1.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_word1: got mux_i=%h busy=%b want 00 1", if1.mux_i, if1.busy);
    end
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      n_checks++; if (if1.ser_valid !== 1'b1 || if1.ser_data !== 1'b0) begin
        n_fail++; $display("FAIL b2b_word1_bit k=%0d: got valid=%b data=%b want 1 0", k, if1.ser_valid, if1.ser_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_parity;
    logic [7:0] words [2];
    logic       pars  [2];
    logic       exp_bit;
    words[0] = 8'h07; pars[0] = 1'b1;
    words[1] = 8'h03; pars[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if1.in_data  = words[w];
      if1.in_valid = 1'b1;
      @(negedge clk);
      if1.in_valid = 1'b0;
      for (int k = 0; k < NB; k++) begin
        @(negedge clk);
        exp_bit = (k < 8) ? words[w][k] : pars[w];
        n_checks++; if (if1.ser_valid !== 1'b1 || if1.ser_data !== exp_bit) begin
          n_fail++; $display("FAIL par_bit w=%h k=%0d: got valid=%b data=%b want 1 %b", words[w], k, if1.ser_valid, if1.ser_data, exp_bit);
        end
        n_checks++; if (if1.ser_last !== (k == NB - 1)) begin n_fail++; $display("FAIL par_last w=%h k=%0d: got %b", words[w], k, if1.ser_last); end
      end
      @(negedge clk);
      n_checks++; if (if1.ser_valid !== 1'b0 || if1.mux_s !== 3'd0) begin
        n_fail++; $display("FAIL par_end w=%h: got valid=%b sel=%0d want 0 0", words[w], if1.ser_valid, if1.mux_s);
      end
    end
  endtask

  task automatic test_glitch;
    logic [7:0] pat;
    logic       b;
    pat = 8'hB4;
    if3.in_data  = 8'h00;
    if3.in_valid = 1'b1;
    @(negedge clk);
    if3.in_valid = 1'b0;
    for (int m = 1; m <= NB * 3; m++) begin
      // mux_y carries the inverse for two cycles and the true bit only before the period's last edge
      b        = ((m - 1) / 3 < 8) ? pat[(m - 1) / 3] : 1'b0;
      glitch_y = (m % 3 == 0) ? b : ~b;
      @(negedge clk);
      n_checks++; if (if3.ser_valid !== (m % 3 == 0)) begin n_fail++; $display("FAIL glitch_valid m=%0d: got %b want %b", m, if3.ser_valid, (m % 3 == 0)); end
      if (m % 3 == 0) begin
        n_checks++; if (if3.ser_data !== b) begin n_fail++; $display("FAIL glitch_data m=%0d: got %b want %b", m, if3.ser_data, b); end
      end
    end
    glitch_y = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midword;
    if4.in_data  = 8'h3C;
    if4.in_valid = 1'b1;
    @(negedge clk);
    if4.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (if4.ser_valid !== 1'b0 || if4.busy !== 1'b0 || if4.ser_last !== 1'b0 || if4.ser_data !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_outs: got valid=%b busy=%b last=%b data=%b want 0 0 0 0", if4.ser_valid, if4.busy, if4.ser_last, if4.ser_data);
    end
    n_checks++; if (if4.mux_s !== 3'd7 || if4.mux_i !== 8'h00) begin
      n_fail++; $display("FAIL mid_rst_mux: got sel=%0d mux_i=%h want 7 00", if4.mux_s, if4.mux_i);
    end
    n_checks++; if (if4.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", if4.in_ready); end
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (if4.ser_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hold: got %b want 0", if4.ser_valid); end
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++; if (if4.ser_valid !== 1'b0 || if4.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL mid_post c=%0d: got valid=%b ready=%b want 0 1", c, if4.ser_valid, if4.in_ready);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    glitch_y     = 1'b0;
    if1.in_data  = 8'h00; if1.in_valid = 1'b0;
    if4.in_data  = 8'h00; if4.in_valid = 1'b0;
    if3.in_data  = 8'h00; if3.in_valid = 1'b0;
    test_reset();
    test_div1_lsb();
    test_div4_msb();
    test_back_to_back();
    test_parity();
    test_glitch();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream controller for the 8:1 mux stage. Accepts an 8-bit parallel word over a valid/ready handshake and holds it on the mux data bus.
- Steps the 3-bit mux select through all eight positions at a programmable rate. Registers the mux's 1-bit output as a serial bitstream with valid and last flags.
- The mux itself stays a separate combinational instance. This block drives its I/S inputs and consumes its Y output, so together they form a parallel-to-serial converter.

Parameters:
- DIV, 1, clock cycles per serial bit (legal range 1..256).
- MSB_FIRST, 0, 0 = select steps 0→7 (LSB first); 1 = select steps 7→0.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  8  parallel word to serialize
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word
- mux_i  output  8  held word, drives mux data inputs
- mux_s  output  3  current select, drives mux select
- mux_y  input  1  mux output (combinational from mux_i/mux_s)
- ser_data  output  1  registered serial bit
- ser_valid  output  1  one-cycle pulse per serial bit
- ser_last  output  1  high with ser_valid on the final bit of a word
- busy  output  1  high while in SHIFT

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (rst high at a clk edge):
  - state=IDLE.
  - mux_i=8'h00; mux_s=0 (7 if MSB_FIRST).
  - ser_data=0, ser_valid=0, ser_last=0, busy=0.
  - Internal div_cnt=0, bit_cnt=0.
- in_ready: combinational, equals (state==IDLE) & ~rst.
- Reset mid-word: the word is discarded. No further ser_valid pulses are produced, and none are produced on the edge where rst is sampled.
- States: IDLE, SHIFT.
- IDLE:
  - ser_valid=0.
  - When in_valid & in_ready at an edge: mux_i<=in_data, mux_s<=start index (0 or 7), div_cnt<=0, bit_cnt<=0, state<=SHIFT, busy<=1.
  - in_data is not sampled at any other time.
- SHIFT, each edge:
  - If div_cnt==DIV-1:
    - ser_data<=mux_y, ser_valid<=1.
    - ser_last<=(bit_cnt==7).
    - div_cnt<=0, bit_cnt<=bit_cnt+1.
    - mux_s advances by +1 (or -1 if MSB_FIRST), 3-bit wrap.
  - Otherwise: div_cnt<=div_cnt+1, ser_valid<=0, ser_last<=0.
  - When bit_cnt==7 and div_cnt==DIV-1: state<=IDLE and busy<=0 on the same edge.
  - mux_s then holds its wrapped value (0 or 7) until the next accept.
- Latency: for the word accepted at edge N, bit k is sampled at edge N+(k+1)·DIV, and ser_valid is visible in the following cycle.
- DIV=1: ser_valid is high for 8 consecutive cycles.
- Throughput: in_ready returns high in the cycle after the last bit. The minimum spacing between accepts is 8·DIV+1 cycles.
- mux_y sampling: mux_y is sampled on the same edge that changes mux_s. Each ser_data bit therefore reflects the select value held during the preceding DIV cycles.
- Stability: mux_i is stable throughout SHIFT, and in_valid/in_data changes during SHIFT are ignored.
- div_cnt width: clog2(DIV)+1 bits. DIV=1 must not produce a zero-width counter.

Optional Feature:
- Macro: MUX_SEL_SEQUENCER_PARITY_EN.
- Defined:
  - After the 8th bit, one extra bit period of DIV cycles emits the even parity (XOR of mux_i) as a 9th ser_valid pulse.
  - ser_last is asserted on the parity bit, not bit 7.
  - The parity bit is computed from mux_i, not mux_y. mux_s is not advanced for it.
  - State returns to IDLE on the parity edge. Accept spacing becomes 9·DIV+1.
- Undefined: exactly 8 bits per word, as described under Behaviour.

Test Plan:
- Reset, then idle: in_ready=1, mux_s=0, ser_valid=0. Hold rst 3 cycles mid-word → outputs return to reset values on the next edge and no stray ser_valid appears.
- DIV=1, MSB_FIRST=0, word 8'hA5 with a real mux instance → 8 consecutive ser_valid pulses, ser_data=1,0,1,0,0,1,0,1, ser_last only on the 8th.
- DIV=4, MSB_FIRST=1, word 8'h3C → ser_valid every 4th cycle, ser_data=0,0,1,1,1,1,0,0, mux_s sequence 7..0; first pulse visible 5 cycles after accept.
- Back-to-back: in_valid held high with words 8'hFF then 8'h00 → second accept occurs exactly 8·DIV+1 cycles after the first; in_ready is low throughout SHIFT; in_data changes during SHIFT do not alter the output.
- Parity macro defined, word 8'h07 → 9 pulses with a parity bit of 1 and ser_last on the 9th. Word 8'h03 → parity bit 0.
- Glitched mux_y (bench forces mux_y toggling mid-period, DIV=3) → ser_data equals the mux_y value present only at the DIV-1 edge.
